reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Parametrised reset manager between the PLL and the design cores. Generalises the fixed "!locked | switch" reset to NUM_SRC debounced, maskable asynchronous request inputs plus PLL lock.
- Drives NUM_DOMAIN active-high synchronous reset outputs, released in a staggered order after a hold-off.
- Also records the cause of the most recent reset and counts reset events for the debug port.

Parameters:
- NUM_SRC, 4, number of external reset-request inputs (switches, buttons, UART break detect).
- NUM_DOMAIN, 3, number of sequenced reset outputs.
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples before a request input changes its debounced value (min 1).
- MIN_ASSERT_CYCLES, 16, minimum cycles spent in ASSERT (min 1).
- HOLDOFF_CYCLES, 256, cycles after a clean lock before the first release (min 1).
- STAGGER_CYCLES, 8, cycles between successive domain releases (min 1).

Ports:
- clock  input  1  system clock (PLL output).
- reset  input  1  asynchronous active-low reset.
- locked  input  1  PLL lock, asynchronous to clock.
- io_req  input  NUM_SRC  reset requests, asynchronous, active-high.
- io_reqMask  input  NUM_SRC  per-bit enable; 1 = request honoured. Quasi-static.
- io_causeClr  input  1  one-cycle pulse that clears io_cause.
- io_rstOut  output  NUM_DOMAIN  active-high synchronous resets; bit 0 is released first.
- io_ready  output  1  high only in RUN.
- io_cause  output  NUM_SRC+1  sticky causes: bit i = io_req[i], bit NUM_SRC = lock loss.
- io_resetCount  output  8  saturating count of entries into ASSERT.

Behaviour:
- Reset low (async): state=ASSERT, io_rstOut=all 1, io_ready=0, io_cause=0, io_resetCount=0, all counters 0, synchronisers 0, debounced values 0.
- Synchronisation: locked and each io_req bit pass through 2-flop synchronisers. Every later reference to these signals uses the synchronised value.
- Debounce: each request bit has its own counter.
  - The counter resets whenever the synchronised sample equals the debounced value.
  - Otherwise it increments. Reaching DEBOUNCE_CYCLES updates the debounced value and clears the counter.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - locked is not debounced.
- fault = !lock_s | |(req_db & io_reqMask).
- FSM, all outputs registered:
  - ASSERT: io_rstOut all 1. The counter runs up to MIN_ASSERT_CYCLES. Go to WAIT_LOCK once the counter is done and fault=0.
  - WAIT_LOCK: go to HOLDOFF on the first cycle with fault=0.
  - HOLDOFF: count HOLDOFF_CYCLES, then go to RELEASE with domain index 0.
  - RELEASE: clear io_rstOut[idx], then wait STAGGER_CYCLES before clearing the next bit. After the last bit clears, go to RUN. Bits already released stay 0.
  - RUN: io_ready=1.
- Fault abort: a fault in any state except ASSERT moves to ASSERT on the next edge. All io_rstOut bits return to 1 on that same edge, all counters clear, and io_ready drops to 0.
- Fault in ASSERT: keeps the MIN counter at 0, which extends the assertion.
- Cause register: on every transition into ASSERT, OR the active fault terms into io_cause.
  - Also OR them in while already in ASSERT.
  - io_causeClr clears io_cause. If a set and a clear land in the same cycle, set wins for the bits being set and all other bits clear.
- io_resetCount increments on each transition into ASSERT from another state and saturates at 255. Leaving async reset does not count.
- Masking: io_reqMask affects only fault and cause. Debouncing keeps running on masked bits, so unmasking an already-debounced high request triggers a fault next cycle.
- Generic case: NUM_DOMAIN=1 gives RELEASE a single step, with no stagger wait after the last bit.

Test Plan:
- Params DEBOUNCE=4, MIN=4, HOLDOFF=8, STAGGER=2, NUM_DOMAIN=3. Deassert reset with locked=1 -> io_rstOut clears bit 0, then bits 1 and 2 at 2-cycle spacing. io_ready=1 after the last bit; io_cause=0 and io_resetCount=0 throughout.
- Apply a 3-cycle pulse on io_req[1] with mask=1111 during RUN -> no reset, because the pulse is shorter than DEBOUNCE. A 10-cycle pulse -> io_rstOut=111 at sync+debounce latency (2+4 cycles), io_cause=00010, io_resetCount=1.
- Drop locked for 1 cycle in mid-RELEASE after domain 0 has released -> io_rstOut returns to 111, io_cause[4]=1, and the full hold-off and stagger sequence restarts.
- Hold io_req[0] high with mask[0]=0 -> no effect. Set mask[0]=1 -> ASSERT next cycle. Keep the request held -> stays in ASSERT beyond MIN_ASSERT_CYCLES.
- Pulse io_causeClr in the same cycle as a new lock loss -> io_cause=10000, with the old request bits cleared.
- Force 300 lock-loss events -> io_resetCount saturates at 255.
- Assert reset low in RUN -> all outputs return to their reset values immediately (asynchronously).

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset manager: synchronises and debounces reset requests plus PLL lock, then releases domains in staggered order.
// Output latency: one cycle from a registered fault to ASSERT; no flow control, outputs are plain registered levels.
module reset_sequencer #(
  parameter int NUM_SRC           = 4,
  parameter int NUM_DOMAIN        = 3,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int HOLDOFF_CYCLES    = 256,
  parameter int STAGGER_CYCLES    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  locked,
  input  logic [NUM_SRC-1:0]    io_req,
  input  logic [NUM_SRC-1:0]    io_reqMask,
  input  logic                  io_causeClr,
  output logic [NUM_DOMAIN-1:0] io_rstOut,
  output logic                  io_ready,
  output logic [NUM_SRC:0]      io_cause,
  output logic [7:0]            io_resetCount
);

  localparam int CMAX_A = (MIN_ASSERT_CYCLES > HOLDOFF_CYCLES) ? MIN_ASSERT_CYCLES : HOLDOFF_CYCLES;
  localparam int CMAX   = (CMAX_A > STAGGER_CYCLES) ? CMAX_A : STAGGER_CYCLES;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW     = (NUM_DOMAIN > 1) ? $clog2(NUM_DOMAIN) : 1;

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_HOLDOFF,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic               lock_meta;
  logic               lock_s;
  logic               lock_seen;
  logic [NUM_SRC-1:0] req_meta;
  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] req_db;
  logic [NUM_SRC-1:0] req_act;
  logic [NUM_SRC:0]   cause_set;
  logic               fault;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      req_meta  <= '0;
      req_s     <= '0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
      req_meta  <= io_req;
      req_s     <= req_meta;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_db
    logic [DW-1:0] db_cnt;
    logic          db_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        db_cnt <= '0;
        db_q   <= 1'b0;
      end else if (req_s[i] == db_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_q   <= req_s[i];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    assign req_db[i] = db_q;
  end

  // Missing lock straight out of reset is power-up, not a loss worth recording.
  assign req_act   = req_db & io_reqMask;
  assign fault     = !lock_s || (|req_act);
  assign cause_set = {!lock_s && lock_seen, req_act};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_ASSERT;
      cnt           <= '0;
      idx           <= '0;
      lock_seen     <= 1'b0;
      io_rstOut     <= '1;
      io_ready      <= 1'b0;
      io_cause      <= '0;
      io_resetCount <= '0;
    end else begin
      if (lock_s) begin
        lock_seen <= 1'b1;
      end
      io_cause <= (io_causeClr ? '0 : io_cause) | cause_set;

      if (state != ST_ASSERT && fault) begin
        state     <= ST_ASSERT;
        cnt       <= '0;
        idx       <= '0;
        io_rstOut <= '1;
        io_ready  <= 1'b0;
        if (io_resetCount != 8'hFF) begin
          io_resetCount <= io_resetCount + 8'd1;
        end
      end else begin
        case (state)
          ST_ASSERT: begin
            if (fault) begin
              cnt <= '0;
            end else if (cnt == CW'(MIN_ASSERT_CYCLES - 1)) begin
              state <= ST_WAIT_LOCK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            state <= ST_HOLDOFF;
            cnt   <= '0;
          end
          ST_HOLDOFF: begin
            if (cnt == CW'(HOLDOFF_CYCLES - 1)) begin
              state <= ST_RELEASE;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RELEASE: begin
            // cnt counts down the stagger gap; a bit is released when it reaches zero.
            if (cnt == '0) begin
              io_rstOut[idx] <= 1'b0;
              if (idx == IW'(NUM_DOMAIN - 1)) begin
                state    <= ST_RUN;
                io_ready <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
                cnt <= CW'(STAGGER_CYCLES - 1);
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_RUN: begin
            io_ready <= 1'b1;
          end
          default: begin
            state <= ST_ASSERT;
          end
        endcase
      end
    end
  end

endmodule
